// File: rtl/noc_input_port.sv
// Router input port: flit FIFO, XY route computation on the head flit, and a
// wormhole FSM that holds the route from head to tail.
module noc_input_port #(
  parameter int FLIT_W  = 16,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 3,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic              req_valid,
  output logic [2:0]        req_dir,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              grant,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [FLIT_W-1:0]  mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  state_t             state_q;
  logic [2:0]         route_q, route_d;
  logic               err_q;

  logic [FLIT_W-1:0]  head;
  logic [1:0]         head_type;
  logic [COORD_W-1:0] dst_x, dst_y;
  logic               empty, push, pop, grant_pop, orphan, head_like;

  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[FLIT_W-1 -: 2];
  assign dst_x     = head[COORD_W-1:0];
  assign dst_y     = head[2*COORD_W-1:COORD_W];
  assign head_like = head_type[1];  // head (10) or single (11)

  assign empty     = (count_q == '0);
  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;

  // In IDLE only a head/single may request; body/tail there is an orphan.
  assign req_valid = !empty && ((state_q == ACTIVE) || head_like);
  assign orphan    = (state_q == IDLE) && !empty && !head_like;
  assign grant_pop = grant && req_valid;
  assign pop       = grant_pop || orphan;

  assign out_flit  = head;
  assign err       = err_q;

  always_comb begin
    route_d = 3'd4;
    if (dst_x > MX)      route_d = 3'd0;
    else if (dst_x < MX) route_d = 3'd1;
    else if (dst_y > MY) route_d = 3'd2;
    else if (dst_y < MY) route_d = 3'd3;
  end

  always_comb begin
    req_dir = 3'd0;
    if (state_q == ACTIVE) req_dir = route_q;
    else if (req_valid)    req_dir = route_d;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      route_q  <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= orphan;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case (state_q)
        IDLE: if (grant_pop && head_type == 2'b10) begin
          state_q <= ACTIVE;
          route_q <= route_d;
        end
        ACTIVE: if (grant_pop && head_type == 2'b01) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at router (2,2): stimulus enqueues the
// expected flit/direction per accepted flit, a monitor checks each granted pop.
module tb_noc_input_port;

  localparam int FLIT_W = 16;

  typedef struct packed {
    logic [FLIT_W-1:0] flit;
    logic [2:0]        dir;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic              req_valid;
  logic [2:0]        req_dir;
  logic [FLIT_W-1:0] out_flit;
  logic              grant;
  logic              err;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  noc_input_port #(.FLIT_W(16), .DEPTH(4), .COORD_W(3), .MY_X(2), .MY_Y(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .req_valid(req_valid), .req_dir(req_dir),
    .out_flit(out_flit), .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] T_HEAD = 2'b10, T_BODY = 2'b00, T_TAIL = 2'b01, T_SGL = 2'b11;

  function automatic logic [FLIT_W-1:0] mk(logic [1:0] t, logic [7:0] tag,
                                           logic [2:0] dx, logic [2:0] dy);
    return {t, tag, dy, dx};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one flit for one edge; record expectation if it will be granted out.
  task automatic push(logic [FLIT_W-1:0] f, logic [2:0] dir, bit track);
    in_valid = 1'b1;
    in_flit  = f;
    if (track) exp_q.push_back('{flit: f, dir: dir});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    grant = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    chk("drain_empty", exp_q.size(), 0);
    step();
    grant = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && req_valid && grant) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pop: got flit %0h dir %0d, expected no pop", out_flit, req_dir);
      end else begin
        e_mon = exp_q.pop_front();
        if (out_flit !== e_mon.flit || req_dir !== e_mon.dir) begin
          fails++;
          $display("FAIL pop_data: got flit %0h dir %0d expected flit %0h dir %0d",
                   out_flit, req_dir, e_mon.flit, e_mon.dir);
        end
      end
    end
  end

  initial begin
    // Reset with in_valid asserted: nothing may be accepted.
    reset = 1'b1; grant = 1'b0; in_valid = 1'b1; in_flit = mk(T_SGL, 8'hAA, 3'd2, 3'd2);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_req_dir", req_dir, 0);
    end
    reset = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_empty", req_valid, 0);

    // Single-flit XY routing.
    begin
      logic [2:0] dxs [5] = '{3'd3, 3'd1, 3'd2, 3'd2, 3'd2};
      logic [2:0] dys [5] = '{3'd2, 3'd2, 3'd3, 3'd1, 3'd2};
      logic [2:0] drs [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      for (int i = 0; i < 5; i++) begin
        push(mk(T_SGL, 8'(8'h10 + i), dxs[i], dys[i]), drs[i], 1'b1);
        chk("single_req_valid", req_valid, 1);
        chk("single_req_dir", req_dir, 32'(drs[i]));
        grant = 1'b1;
        step();
        grant = 1'b0;
        chk("single_popped", req_valid, 0);
      end
    end

    // Wormhole packet with grant held; then a fresh packet re-routes.
    grant = 1'b1;
    push(mk(T_HEAD, 8'h21, 3'd5, 3'd0), 3'd0, 1'b1);
    push(mk(T_BODY, 8'h22, 3'd0, 3'd0), 3'd0, 1'b1);
    push(mk(T_BODY, 8'h23, 3'd7, 3'd7), 3'd0, 1'b1);
    push(mk(T_TAIL, 8'h24, 3'd1, 3'd1), 3'd0, 1'b1);
    push(mk(T_HEAD, 8'h25, 3'd0, 3'd2), 3'd1, 1'b1);
    push(mk(T_TAIL, 8'h26, 3'd5, 3'd5), 3'd1, 1'b1);
    drain();

    // Full / backpressure.
    push(mk(T_HEAD, 8'h31, 3'd3, 3'd2), 3'd0, 1'b1);
    push(mk(T_BODY, 8'h32, 3'd0, 3'd0), 3'd0, 1'b1);
    push(mk(T_BODY, 8'h33, 3'd0, 3'd0), 3'd0, 1'b1);
    chk("not_full_at_3", in_ready, 1);
    push(mk(T_TAIL, 8'h34, 3'd0, 3'd0), 3'd0, 1'b1);
    chk("full_in_ready", in_ready, 0);
    push(mk(T_SGL, 8'h3F, 3'd1, 3'd1), 3'd3, 1'b0);
    chk("full_rejects", in_ready, 0);
    chk("full_req_dir", req_dir, 0);
    grant = 1'b1;
    step();
    grant = 1'b0;
    chk("one_grant_ready", in_ready, 1);
    grant = 1'b1;
    push(mk(T_SGL, 8'h35, 3'd2, 3'd2), 3'd4, 1'b1);
    grant = 1'b0;
    chk("push_pop_ready", in_ready, 1);
    push(mk(T_SGL, 8'h36, 3'd1, 3'd2), 3'd1, 1'b1);
    chk("push_pop_kept_3", in_ready, 0);
    drain();

    // Orphan body in IDLE is dropped with a one-cycle err pulse.
    push(mk(T_BODY, 8'h41, 3'd0, 3'd0), 3'd0, 1'b0);
    chk("orphan_no_req", req_valid, 0);
    chk("orphan_err_before", err, 0);
    step();
    chk("orphan_err", err, 1);
    chk("orphan_dropped", req_valid, 0);
    step();
    chk("orphan_err_end", err, 0);
    push(mk(T_HEAD, 8'h42, 3'd2, 3'd3), 3'd2, 1'b1);
    chk("post_orphan_dir", req_dir, 2);
    chk("post_orphan_valid", req_valid, 1);
    push(mk(T_TAIL, 8'h43, 3'd0, 3'd0), 3'd2, 1'b1);
    drain();

    // Reset mid-packet.
    grant = 1'b1;
    push(mk(T_HEAD, 8'h51, 3'd5, 3'd0), 3'd0, 1'b1);
    push(mk(T_BODY, 8'h52, 3'd0, 3'd0), 3'd0, 1'b1);
    step();
    grant = 1'b0;
    chk("active_empty_dir", req_dir, 0);
    chk("active_empty_valid", req_valid, 0);
    push(mk(T_BODY, 8'h53, 3'd1, 3'd4), 3'd0, 1'b0);
    chk("active_body_valid", req_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", req_valid, 0);
    chk("midrst_dir", req_dir, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_err", err, 0);
    push(mk(T_HEAD, 8'h54, 3'd0, 3'd2), 3'd1, 1'b1);
    chk("midrst_reroute", req_dir, 1);
    push(mk(T_TAIL, 8'h55, 3'd0, 3'd0), 3'd1, 1'b1);
    drain();

    chk("queue_final", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
